// File: rtl/frame_dmac_restore_pkg.sv
// Shared definitions for the host-transmit DMAC restore stage.
// Packet word layout: [133] head, [132] tail, [131:128] valid bytes - 1, [127:0] data with byte 0
// in the MSBs. The TSN tag (bytes 0..5) that carries the DMAC occupies data[127:80].
package frame_dmac_restore_pkg;

  localparam int unsigned PKT_W    = 134;
  localparam int unsigned HEAD_BIT = 133;
  localparam int unsigned TAIL_BIT = 132;
  localparam int unsigned DMAC_MSB = 127;
  localparam int unsigned DMAC_LSB = 80;
  localparam int unsigned DMAC_W   = DMAC_MSB - DMAC_LSB + 1;

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    READ_S    = 2'd1,
    DRAIN_S   = 2'd2,
    RELEASE_S = 2'd3
  } state_e;

  // Overwrite the DMAC field of a head word, leaving every other bit untouched.
  function automatic logic [PKT_W-1:0] put_dmac(input logic [PKT_W-1:0] word,
                                                input logic [DMAC_W-1:0] dmac);
    logic [PKT_W-1:0] res;
    res = word;
    res[DMAC_MSB:DMAC_LSB] = dmac;
    return res;
  endfunction

endpackage

// File: rtl/frame_dmac_restore_desc_fifo.sv
// Synchronous descriptor FIFO with a registered occupancy count.
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, iv_wdata write strobe and data (ignored while full)
//   i_pop            read strobe (ignored while empty); ov_rdata shows the head entry
//   o_full, o_empty  occupancy flags derived from the registered count
module frame_dmac_restore_desc_fifo
  import frame_dmac_restore_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 59
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] iv_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] ov_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full   = (r_count == FULL_CNT);
  assign o_empty  = (r_count == '0);
  assign w_push   = i_push && !o_full;
  assign w_pop    = i_pop && !o_empty;
  assign ov_rdata = r_mem[r_rptr];

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= iv_wdata;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/frame_dmac_restore.sv
// Downstream stage of the inverse-mapping lookup: queues result descriptors, reads each frame
// from the packet buffer, restores the DMAC in the head word when requested, streams matched
// frames to the host port and returns every processed bufid to the buffer manager once.
// Ports:
//   i_clk, i_rst_n                     clock, asynchronous active-low reset
//   iv_dmac, iv_bufid,                 descriptor fields
//   i_dmac_replace_flag, i_match_flag
//   i_descriptor_wr/o_descriptor_ready descriptor handshake
//   o_pkt_rd, ov_pkt_raddr             packet-RAM read, address {bufid, word index}
//   iv_pkt_rdata                       packet-RAM data, valid RD_LAT cycles after o_pkt_rd
//   ov_data, o_data_wr                 output frame words
//   ov_bufid_release, o_bufid_release_wr  buffer release pulse
//   o_frame_err                        pulse when no tail is found within the buffer
module frame_dmac_restore
  import frame_dmac_restore_pkg::*;
#(
  parameter int unsigned DESC_DEPTH = 4,
  parameter int unsigned RD_LAT     = 2,
  parameter int unsigned BUFID_W    = 9,
  parameter int unsigned WIDX_W     = 7
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DMAC_W-1:0]         iv_dmac,
  input  logic [BUFID_W-1:0]        iv_bufid,
  input  logic                      i_dmac_replace_flag,
  input  logic                      i_match_flag,
  input  logic                      i_descriptor_wr,
  output logic                      o_descriptor_ready,
  output logic                      o_pkt_rd,
  output logic [BUFID_W+WIDX_W-1:0] ov_pkt_raddr,
  input  logic [PKT_W-1:0]          iv_pkt_rdata,
  output logic [PKT_W-1:0]          ov_data,
  output logic                      o_data_wr,
  output logic [BUFID_W-1:0]        ov_bufid_release,
  output logic                      o_bufid_release_wr,
  output logic                      o_frame_err
);

  localparam int unsigned DESC_W = 2 + BUFID_W + DMAC_W;

  state_e              r_state;
  logic                r_ready_en;
  logic                r_replace;
  logic                r_match;
  logic [BUFID_W-1:0]  r_bufid;
  logic [DMAC_W-1:0]   r_dmac;
  logic [WIDX_W-1:0]   r_widx;
  logic [WIDX_W-1:0]   r_ridx;
  logic                r_seen_head;
  logic                r_pkt_rd;
  logic [RD_LAT-1:0]   r_vld_sr;
  logic [PKT_W-1:0]    r_data;
  logic                r_data_wr;
  logic [BUFID_W-1:0]  r_rel_bufid;
  logic                r_rel_wr;
  logic                r_frame_err;

  logic [DESC_W-1:0]   w_desc_wdata;
  logic [DESC_W-1:0]   w_desc_rdata;
  logic                w_full;
  logic                w_empty;
  logic                w_pop;
  logic [RD_LAT:0]     w_vld_shift;
  logic                w_rvalid;
  logic                w_is_head;
  logic                w_is_tail;
  logic                w_last_ret;
  logic                w_fwd;
  logic [PKT_W-1:0]    w_out_word;

  assign w_desc_wdata       = {i_dmac_replace_flag, i_match_flag, iv_bufid, iv_dmac};
  // Ready is held low until the first clock after reset is released.
  assign o_descriptor_ready = r_ready_en && !w_full;
  assign w_pop              = (r_state == IDLE_S) && !w_empty;

  frame_dmac_restore_desc_fifo #(
    .DEPTH (DESC_DEPTH),
    .WIDTH (DESC_W)
  ) u_desc_fifo (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_push   (i_descriptor_wr && o_descriptor_ready),
    .iv_wdata (w_desc_wdata),
    .i_pop    (w_pop),
    .ov_rdata (w_desc_rdata),
    .o_full   (w_full),
    .o_empty  (w_empty)
  );

  // Each issued read is tagged so that its data can be recognised RD_LAT cycles later.
  assign w_vld_shift = {r_vld_sr, r_pkt_rd};
  // Returns outside READ_S belong to reads issued past the tail and are discarded.
  assign w_rvalid    = r_vld_sr[RD_LAT-1] && (r_state == READ_S);
  assign w_is_head   = iv_pkt_rdata[HEAD_BIT];
  assign w_is_tail   = iv_pkt_rdata[TAIL_BIT];
  assign w_last_ret  = (r_ridx == {WIDX_W{1'b1}});
  assign w_fwd       = w_rvalid && r_match && (w_is_head || r_seen_head);

  always_comb begin
    w_out_word = iv_pkt_rdata;
    if (w_is_head && r_replace) begin
      w_out_word = put_dmac(iv_pkt_rdata, r_dmac);
    end
    // Last word of the buffer closes the frame even if the tail bit was missing.
    if (w_last_ret) begin
      w_out_word[TAIL_BIT] = 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= IDLE_S;
      r_ready_en  <= 1'b0;
      r_replace   <= 1'b0;
      r_match     <= 1'b0;
      r_bufid     <= '0;
      r_dmac      <= '0;
      r_widx      <= '0;
      r_ridx      <= '0;
      r_seen_head <= 1'b0;
      r_pkt_rd    <= 1'b0;
      r_vld_sr    <= '0;
      r_data      <= '0;
      r_data_wr   <= 1'b0;
      r_rel_bufid <= '0;
      r_rel_wr    <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_ready_en  <= 1'b1;
      r_vld_sr    <= w_vld_shift[RD_LAT-1:0];
      r_data_wr   <= 1'b0;
      r_rel_wr    <= 1'b0;
      r_frame_err <= 1'b0;
      if (w_fwd) begin
        r_data    <= w_out_word;
        r_data_wr <= 1'b1;
      end
      unique case (r_state)
        IDLE_S: begin
          if (!w_empty) begin
            {r_replace, r_match, r_bufid, r_dmac} <= w_desc_rdata;
            r_widx      <= '0;
            r_ridx      <= '0;
            r_seen_head <= 1'b0;
            r_pkt_rd    <= 1'b1;
            r_state     <= READ_S;
          end
        end
        READ_S: begin
          if (r_pkt_rd) begin
            if (r_widx == {WIDX_W{1'b1}}) begin
              r_pkt_rd <= 1'b0;
            end else begin
              r_widx <= r_widx + 1'b1;
            end
          end
          if (w_rvalid) begin
            r_ridx <= r_ridx + 1'b1;
            if (w_is_head) begin
              r_seen_head <= 1'b1;
            end
            if (w_is_tail || w_last_ret) begin
              r_pkt_rd    <= 1'b0;
              r_frame_err <= !w_is_tail;
              r_state     <= DRAIN_S;
            end
          end
        end
        DRAIN_S: begin
          if (r_vld_sr == '0) begin
            r_state <= RELEASE_S;
          end
        end
        RELEASE_S: begin
          r_rel_bufid <= r_bufid;
          r_rel_wr    <= 1'b1;
          r_state     <= IDLE_S;
        end
        default: r_state <= IDLE_S;
      endcase
    end
  end

  assign o_pkt_rd           = r_pkt_rd;
  assign ov_pkt_raddr       = {r_bufid, r_widx};
  assign ov_data            = r_data;
  assign o_data_wr          = r_data_wr;
  assign ov_bufid_release   = r_rel_bufid;
  assign o_bufid_release_wr = r_rel_wr;
  assign o_frame_err        = r_frame_err;

endmodule

// File: tb/tb_frame_dmac_restore.sv
// Self-checking bench: packet-RAM model, frame-level reference model (expected word and release
// queues built from buffer contents), directed vector table, back-pressure, random and reset cases.
module tb_frame_dmac_restore;

  localparam int RD_LAT = 2;
  typedef logic [133:0] w_t;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [47:0]  iv_dmac = '0;
  logic [8:0]   iv_bufid = '0;
  logic         i_dmac_replace_flag = 1'b0;
  logic         i_match_flag = 1'b0;
  logic         i_descriptor_wr = 1'b0;
  logic         o_descriptor_ready;
  logic         o_pkt_rd;
  logic [15:0]  ov_pkt_raddr;
  logic [133:0] iv_pkt_rdata;
  logic [133:0] ov_data;
  logic         o_data_wr;
  logic [8:0]   ov_bufid_release;
  logic         o_bufid_release_wr;
  logic         o_frame_err;

  always #5 i_clk = ~i_clk;

  frame_dmac_restore #(
    .DESC_DEPTH (4),
    .RD_LAT     (RD_LAT),
    .BUFID_W    (9),
    .WIDX_W     (7)
  ) dut (
    .i_clk               (i_clk),
    .i_rst_n             (i_rst_n),
    .iv_dmac             (iv_dmac),
    .iv_bufid            (iv_bufid),
    .i_dmac_replace_flag (i_dmac_replace_flag),
    .i_match_flag        (i_match_flag),
    .i_descriptor_wr     (i_descriptor_wr),
    .o_descriptor_ready  (o_descriptor_ready),
    .o_pkt_rd            (o_pkt_rd),
    .ov_pkt_raddr        (ov_pkt_raddr),
    .iv_pkt_rdata        (iv_pkt_rdata),
    .ov_data             (ov_data),
    .o_data_wr           (o_data_wr),
    .ov_bufid_release    (ov_bufid_release),
    .o_bufid_release_wr  (o_bufid_release_wr),
    .o_frame_err         (o_frame_err)
  );

  function automatic w_t rnd_word();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom, $urandom, $urandom};
    return r[133:0];
  endfunction

  function automatic logic [47:0] rnd48();
    logic [63:0] r;
    r = {$urandom, $urandom};
    return r[47:0];
  endfunction

  // Packet RAM: data appears RD_LAT cycles after the read; junk when no read was issued.
  w_t mem [65536];
  w_t pipe [RD_LAT];
  always @(posedge i_clk) begin
    pipe[0] <= o_pkt_rd ? mem[ov_pkt_raddr] : rnd_word();
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign iv_pkt_rdata = pipe[RD_LAT-1];

  int n_tests = 0;
  int n_fail = 0;
  w_t exp_q[$];
  logic [8:0] exp_rel[$];
  int exp_err = 0;
  int out_cnt = 0, rel_cnt = 0, err_cnt = 0, rd_cnt = 0, rd_last = 0;
  logic [47:0] last_head_dmac = '0;
  logic [8:0] last_rel = '0;
  bit saw_busy = 1'b0;
  w_t mon_w;
  logic [8:0] mon_b;

  task automatic chk(input string name, input bit ok, input w_t act, input w_t exp);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Frame of nwords words (0 = no tail anywhere); junk with random flags after the tail.
  task automatic build_frame(input logic [8:0] b, input int nwords);
    w_t w;
    for (int i = 0; i < 128; i++) begin
      w = rnd_word();
      w[133] = (i == 0);
      w[132] = (nwords != 0) && (i == nwords - 1);
      if (nwords != 0 && i >= nwords) w[133:132] = 2'($urandom);
      mem[{b, 7'(i)}] = w;
    end
  endtask

  // Reference: frame runs to the first tail word (or the whole buffer, tail forced, error).
  task automatic model_accept(input logic [8:0] b, input logic [47:0] d, input bit rep,
                              input bit m);
    int t;
    int last;
    w_t w;
    t = -1;
    for (int i = 0; i < 128; i++) begin
      w = mem[{b, 7'(i)}];
      if (t < 0 && w[132]) t = i;
    end
    last = (t < 0) ? 127 : t;
    if (m) begin
      for (int i = 0; i <= last; i++) begin
        w = mem[{b, 7'(i)}];
        if (i == 0 && rep) w[127:80] = d;
        if (i == last) w[132] = 1'b1;
        exp_q.push_back(w);
      end
    end
    if (t < 0) exp_err++;
    exp_rel.push_back(b);
  endtask

  task automatic push(input logic [8:0] b, input logic [47:0] d, input bit rep, input bit m);
    int t;
    iv_bufid = b;
    iv_dmac = d;
    i_dmac_replace_flag = rep;
    i_match_flag = m;
    i_descriptor_wr = 1'b1;
    t = 0;
    while (!o_descriptor_ready && t < 20000) begin
      saw_busy = 1'b1;
      @(negedge i_clk);
      t++;
    end
    if (t >= 20000) chk("push_timeout", 1'b0, w_t'(t), w_t'(20000));
    else model_accept(b, d, rep, m);
    @(negedge i_clk);
    i_descriptor_wr = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (exp_rel.size() != 0 && t < 5000) begin
      @(negedge i_clk);
      t++;
    end
    chk("idle_timeout", t < 5000, w_t'(t), w_t'(5000));
    repeat (4) @(negedge i_clk);
  endtask

  always @(negedge i_clk) begin
    if (i_rst_n) begin
      if (o_pkt_rd) begin
        if (exp_rel.size() == 0) chk("rd_unexpected", 1'b0, w_t'(ov_pkt_raddr), '0);
        else chk("rd_addr", (ov_pkt_raddr == {exp_rel[0], rd_cnt[6:0]}) && (rd_cnt < 128),
                 w_t'(ov_pkt_raddr), w_t'({exp_rel[0], rd_cnt[6:0]}));
        rd_cnt++;
      end
      if (o_data_wr) begin
        out_cnt++;
        if (ov_data[133]) last_head_dmac = ov_data[127:80];
        if (exp_q.size() == 0) chk("data_unexpected", 1'b0, ov_data, '0);
        else begin
          mon_w = exp_q.pop_front();
          chk("data", ov_data == mon_w, ov_data, mon_w);
        end
      end
      if (o_bufid_release_wr) begin
        rel_cnt++;
        last_rel = ov_bufid_release;
        rd_last = rd_cnt;
        rd_cnt = 0;
        if (exp_rel.size() == 0) chk("release_unexpected", 1'b0, w_t'(ov_bufid_release), '0);
        else begin
          mon_b = exp_rel.pop_front();
          chk("release", ov_bufid_release == mon_b, w_t'(ov_bufid_release), w_t'(mon_b));
        end
      end
      if (o_frame_err) err_cnt++;
    end
  end

  typedef struct {
    logic [8:0]  bufid;
    logic [47:0] dmac;
    bit          rep;
    bit          m;
    int          nwords;
    int          exp_out;
    int          exp_err;
  } vec_t;

  vec_t tbl [7];
  logic [28:0] ctl;

  initial begin
    int o0, r0, e0, t;
    tbl[0] = '{9'h005, 48'h001122334455, 1'b1, 1'b1, 3, 3, 0};
    tbl[1] = '{9'h033, 48'hA5A5_0F0F_1234, 1'b0, 1'b1, 5, 5, 0};
    tbl[2] = '{9'h1FF, 48'hDEAD_BEEF_0001, 1'b1, 1'b0, 4, 0, 0};
    tbl[3] = '{9'h040, 48'h0102_0304_0506, 1'b1, 1'b1, 1, 1, 0};
    tbl[4] = '{9'h041, 48'hCAFE_F00D_7777, 1'b1, 1'b1, 0, 128, 1};
    tbl[5] = '{9'h042, 48'h1111_2222_3333, 1'b0, 1'b0, 0, 0, 1};
    tbl[6] = '{9'h043, 48'h9999_8888_7777, 1'b1, 1'b1, 128, 128, 0};

    repeat (2) @(negedge i_clk);
    ctl = {o_data_wr, o_pkt_rd, ov_pkt_raddr, o_bufid_release_wr, ov_bufid_release, o_frame_err};
    chk("reset_ctl", ctl == '0, w_t'(ctl), '0);
    chk("reset_data", ov_data == '0, ov_data, '0);
    chk("reset_ready", o_descriptor_ready == 1'b0, w_t'(o_descriptor_ready), '0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("ready_after_reset", o_descriptor_ready == 1'b1, w_t'(o_descriptor_ready), w_t'(1));

    for (int k = 0; k < 7; k++) begin
      build_frame(tbl[k].bufid, tbl[k].nwords);
      o0 = out_cnt; r0 = rel_cnt; e0 = err_cnt;
      last_head_dmac = '0;
      push(tbl[k].bufid, tbl[k].dmac, tbl[k].rep, tbl[k].m);
      wait_idle();
      chk("vec_nout", out_cnt - o0 == tbl[k].exp_out, w_t'(out_cnt - o0), w_t'(tbl[k].exp_out));
      chk("vec_nrel", rel_cnt - r0 == 1, w_t'(rel_cnt - r0), w_t'(1));
      chk("vec_relid", last_rel == tbl[k].bufid, w_t'(last_rel), w_t'(tbl[k].bufid));
      chk("vec_nerr", err_cnt - e0 == tbl[k].exp_err, w_t'(err_cnt - e0), w_t'(tbl[k].exp_err));
      if (k == 0) chk("vec_head_dmac", last_head_dmac == 48'h001122334455,
                      w_t'(last_head_dmac), w_t'(48'h001122334455));
      if (tbl[k].exp_err != 0) chk("vec_nreads", rd_last == 128, w_t'(rd_last), w_t'(128));
    end

    // Back-pressure: long frames keep the FIFO full so the source has to hold.
    for (int k = 0; k < 6; k++) build_frame(9'h060 + 9'(k), 30);
    o0 = out_cnt; r0 = rel_cnt;
    saw_busy = 1'b0;
    for (int k = 0; k < 6; k++) push(9'h060 + 9'(k), rnd48(), k[0], 1'b1);
    chk("bp_ready_dropped", saw_busy, w_t'(saw_busy), w_t'(1));
    wait_idle();
    chk("bp_nout", out_cnt - o0 == 180, w_t'(out_cnt - o0), w_t'(180));
    chk("bp_nrel", rel_cnt - r0 == 6, w_t'(rel_cnt - r0), w_t'(6));

    // Random frames against the reference model.
    for (int k = 0; k < 25; k++) begin
      t = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 24));
      build_frame(9'h080 + 9'(k), t);
      repeat ($urandom_range(0, 3)) @(negedge i_clk);
      push(9'h080 + 9'(k), rnd48(), 1'($urandom), $urandom_range(0, 3) != 0);
    end
    wait_idle();
    chk("rand_queue_empty", exp_q.size() == 0, w_t'(exp_q.size()), '0);
    chk("rand_err_total", err_cnt == exp_err, w_t'(err_cnt), w_t'(exp_err));

    // Reset in the middle of a frame with further descriptors queued.
    build_frame(9'h100, 100);
    build_frame(9'h101, 5);
    build_frame(9'h102, 5);
    push(9'h100, rnd48(), 1'b1, 1'b1);
    push(9'h101, rnd48(), 1'b1, 1'b1);
    push(9'h102, rnd48(), 1'b0, 1'b1);
    o0 = out_cnt; t = 0;
    while (out_cnt - o0 < 10 && t < 2000) begin
      @(negedge i_clk);
      t++;
    end
    chk("mid_frame_progress", t < 2000, w_t'(t), w_t'(2000));
    #2;
    i_rst_n = 1'b0;
    exp_q.delete();
    exp_rel.delete();
    rd_cnt = 0;
    #1;
    ctl = {o_data_wr, o_pkt_rd, ov_pkt_raddr, o_bufid_release_wr, ov_bufid_release, o_frame_err};
    chk("midreset_ctl", ctl == '0, w_t'(ctl), '0);
    chk("midreset_data", ov_data == '0, ov_data, '0);
    repeat (3) @(negedge i_clk);
    chk("midreset_ready", o_descriptor_ready == 1'b0, w_t'(o_descriptor_ready), '0);
    i_rst_n = 1'b1;
    @(negedge i_clk);
    chk("midreset_ready_after", o_descriptor_ready == 1'b1, w_t'(o_descriptor_ready), w_t'(1));
    repeat (10) @(negedge i_clk);
    build_frame(9'h103, 6);
    o0 = out_cnt; r0 = rel_cnt;
    push(9'h103, 48'h0A0B_0C0D_0E0F, 1'b1, 1'b1);
    wait_idle();
    chk("post_reset_nout", out_cnt - o0 == 6, w_t'(out_cnt - o0), w_t'(6));
    chk("post_reset_nrel", rel_cnt - r0 == 1, w_t'(rel_cnt - r0), w_t'(1));
    chk("post_reset_relid", last_rel == 9'h103, w_t'(last_rel), w_t'(9'h103));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
